// File: rtl/uart_transmitter_configurable_if.sv
// Producer-side connection of the UART transmitter: byte enqueue strobe
// plus the FIFO status flags returned to the producer.
interface uart_transmitter_configurable_if;
    logic [7:0] data_in;
    logic       write_enable;
    logic       buffer_full;
    logic       buffer_empty;
    logic       overflow;

    modport master (
        output data_in, write_enable,
        input  buffer_full, buffer_empty, overflow
    );

    modport slave (
        input  data_in, write_enable,
        output buffer_full, buffer_empty, overflow
    );
endinterface

// File: rtl/uart_transmitter_configurable.sv
// UART transmitter with a TX FIFO and per-frame data length, parity, stop bits
// and baud divisor, all latched when the byte is popped.
module uart_transmitter_configurable #(
    parameter int FIFO_DEPTH      = 64,
    parameter int THRESHOLD_WIDTH = $clog2(FIFO_DEPTH),
    parameter int DIVISOR_0       = 5208,
    parameter int DIVISOR_1       = 2604,
    parameter int DIVISOR_2       = 434,
    parameter int DIVISOR_3       = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    uart_transmitter_configurable_if.slave fifo_bus,
    input  logic [THRESHOLD_WIDTH-1:0]     buffer_full_threshold,
    input  logic [1:0]                     baudrate_select,
    input  logic [1:0]                     data_bits_select,
    input  logic [1:0]                     parity_mode,
    input  logic                           stop_bits_select,
    output logic                           busy,
    output logic                           data_out
);
    localparam int ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int DIV_A   = (DIVISOR_0 > DIVISOR_1) ? DIVISOR_0 : DIVISOR_1;
    localparam int DIV_B   = (DIVISOR_2 > DIVISOR_3) ? DIVISOR_2 : DIVISOR_3;
    localparam int DIV_MAX = (DIV_A > DIV_B) ? DIV_A : DIV_B;
    localparam int CNT_W   = $clog2(DIV_MAX);
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    function automatic logic [CNT_W-1:0] reload_for(input logic [1:0] sel);
        case (sel)
            2'd0:    return CNT_W'(DIVISOR_0 - 1);
            2'd1:    return CNT_W'(DIVISOR_1 - 1);
            2'd2:    return CNT_W'(DIVISOR_2 - 1);
            default: return CNT_W'(DIVISOR_3 - 1);
        endcase
    endfunction

    logic [7:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              overflow_q;

    state_t            state;
    logic [CNT_W-1:0]  baud_cnt;
    logic [CNT_W-1:0]  reload_q;
    logic [7:0]        shift_q;
    logic [2:0]        bit_idx;
    logic [2:0]        last_bit_q;
    logic              parity_en_q;
    logic              parity_q;
    logic              stop2_q;
    logic              stop_left;

    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              bit_done;
    logic              frame_end;
    logic [7:0]        head;
    logic [7:0]        data_mask;

    assign fifo_full  = (count == DEPTH_CNT);
    assign push       = fifo_bus.write_enable && !fifo_full;
    assign bit_done   = (baud_cnt == '0);
    assign frame_end  = (state == STOP) && bit_done && !stop_left;
    // A pop happens from IDLE or on the edge that closes the last stop bit,
    // which is what gives back-to-back frames with no idle cycle.
    assign pop        = (count != '0) && ((state == IDLE) || frame_end);
    assign head       = mem[rd_ptr];
    assign data_mask  = 8'hFF >> (2'd3 - data_bits_select);

    assign fifo_bus.buffer_full  = int'(count) >= int'(buffer_full_threshold);
    assign fifo_bus.buffer_empty = (count == '0);
    assign fifo_bus.overflow     = overflow_q;

    always_ff @(posedge clock) begin
        if (push && !reset) begin
            mem[wr_ptr] <= fifo_bus.data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            data_out   <= 1'b1;
            busy       <= 1'b0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            stop_left  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (fifo_bus.write_enable && fifo_full) overflow_q <= 1'b1;

            if (state != IDLE && !bit_done) baud_cnt <= baud_cnt - 1'b1;

            case (state)
                START: begin
                    if (bit_done) begin
                        baud_cnt <= reload_q;
                        bit_idx  <= '0;
                        data_out <= shift_q[0];
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= reload_q;
                        if (bit_idx == last_bit_q) begin
                            if (parity_en_q) begin
                                data_out <= parity_q;
                                state    <= PARITY;
                            end else begin
                                data_out  <= 1'b1;
                                stop_left <= stop2_q;
                                state     <= STOP;
                            end
                        end else begin
                            bit_idx  <= bit_idx + 1'b1;
                            shift_q  <= shift_q >> 1;
                            data_out <= shift_q[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        baud_cnt  <= reload_q;
                        data_out  <= 1'b1;
                        stop_left <= stop2_q;
                        state     <= STOP;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (stop_left) begin
                            baud_cnt  <= reload_q;
                            stop_left <= 1'b0;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: ;
            endcase

            // Frame setup overrides the STOP exit so the next start bit
            // follows the last stop bit directly.
            if (pop) begin
                state       <= START;
                busy        <= 1'b1;
                data_out    <= 1'b0;
                baud_cnt    <= reload_for(baudrate_select);
                reload_q    <= reload_for(baudrate_select);
                shift_q     <= head;
                last_bit_q  <= 3'd4 + {1'b0, data_bits_select};
                parity_en_q <= (parity_mode == 2'd1) || (parity_mode == 2'd2);
                parity_q    <= (^(head & data_mask)) ^ (parity_mode == 2'd2);
                stop2_q     <= stop_bits_select;
            end
        end
    end
endmodule

// File: tb/tb_uart_transmitter_configurable.sv
// Bench for uart_transmitter_configurable: a queue-based line model checked
// every cycle, plus literal frame shapes and lengths for directed cases.
`timescale 1ns/1ps
module tb_uart_transmitter_configurable;
    localparam int FD = 4;
    localparam int TW = 2;
    localparam int D0 = 6;
    localparam int D1 = 3;
    localparam int D2 = 5;
    localparam int D3 = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [TW-1:0] thr   = '0;
    logic [1:0]    baud  = 2'd3;
    logic [1:0]    dbits = 2'd3;
    logic [1:0]    pmode = 2'd0;
    logic          stop2 = 1'b0;
    logic          busy;
    logic          data_out;

    uart_transmitter_configurable_if bus();

    uart_transmitter_configurable #(
        .FIFO_DEPTH(FD), .THRESHOLD_WIDTH(TW),
        .DIVISOR_0(D0), .DIVISOR_1(D1), .DIVISOR_2(D2), .DIVISOR_3(D3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .fifo_bus(bus.slave),
        .buffer_full_threshold(thr),
        .baudrate_select(baud),
        .data_bits_select(dbits),
        .parity_mode(pmode),
        .stop_bits_select(stop2),
        .busy(busy),
        .data_out(data_out)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    // Line model: the FIFO is a queue of bytes, the transmitter is a queue of
    // per-cycle line levels for the frame in flight.
    logic [7:0] mq[$];
    logic       wave[$];
    logic       m_ovf = 1'b0;
    bit         armed = 1'b0;
    int         divtab[4] = '{D0, D1, D2, D3};

    function automatic void build(input logic [7:0] b);
        logic line_bits[$];
        int   n;
        int   ones;
        n    = 5 + int'(dbits);
        ones = 0;
        line_bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            line_bits.push_back(b[i]);
            if (b[i]) ones++;
        end
        if (pmode == 2'd1) line_bits.push_back((ones % 2) == 1);
        if (pmode == 2'd2) line_bits.push_back((ones % 2) == 0);
        line_bits.push_back(1'b1);
        if (stop2) line_bits.push_back(1'b1);
        foreach (line_bits[i])
            for (int c = 0; c < divtab[baud]; c++) wave.push_back(line_bits[i]);
    endfunction

    always @(posedge clock) begin : model
        int pre;
        if (reset) begin
            mq.delete();
            wave.delete();
            m_ovf = 1'b0;
            armed = 1'b1;
        end else begin
            pre = mq.size();
            if (wave.size() > 0) void'(wave.pop_front());
            if (wave.size() == 0 && pre > 0) build(mq.pop_front());
            if (bus.write_enable) begin
                if (pre < FD) mq.push_back(bus.data_in);
                else          m_ovf = 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        if (armed) begin
            chk("m_data_out", data_out, (wave.size() > 0) ? wave[0] : 1'b1);
            chk("m_busy", busy, wave.size() > 0);
            chk("m_empty", bus.buffer_empty, mq.size() == 0);
            chk("m_full", bus.buffer_full, mq.size() >= int'(thr));
            chk("m_overflow", bus.overflow, m_ovf);
        end
    end

    int run = 0;
    int last_run = 0;
    always @(negedge clock) begin
        if (busy === 1'b1) run++;
        else if (run > 0) begin
            last_run = run;
            run = 0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.data_in      = b;
        bus.write_enable = 1'b1;
        tick();
        bus.write_enable = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 5000) begin
            @(negedge clock);
            t++;
        end
        if (t >= 5000) chk_int("idle_timeout", t, 0);
        @(negedge clock);
        tick();
    endtask

    task automatic send_capture(input logic [7:0] b, input int div,
                                output logic [15:0] bits, output int blen);
        logic tr[$];
        int   t;
        write_byte(b);
        @(negedge clock);
        chk("lat_not_empty", bus.buffer_empty, 1'b0);
        chk("lat_not_busy", busy, 1'b0);
        @(negedge clock);
        chk("lat_busy", busy, 1'b1);
        chk("lat_start_bit", data_out, 1'b0);
        t = 0;
        while (busy === 1'b1 && t < 4000) begin
            tr.push_back(data_out);
            @(negedge clock);
            t++;
        end
        if (t >= 4000) chk_int("frame_timeout", t, 0);
        chk("line_high_after", data_out, 1'b1);
        blen = tr.size();
        bits = '0;
        for (int k = 0; k < 16; k++)
            if ((k + 1) * div <= blen) bits[k] = tr[k * div + div / 2];
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [15:0] bits;
        int          blen;
        bus.data_in      = 8'h00;
        bus.write_enable = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_data_out", data_out, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_empty", bus.buffer_empty, 1'b1);
        chk("rst_overflow", bus.overflow, 1'b0);
        chk("rst_full_thr0", bus.buffer_full, 1'b1);
        tick();
        reset = 1'b0;
        thr   = 2'd3;
        repeat (3) tick();

        // 8N1, 0xA5
        baud = 2'd3; dbits = 2'd3; pmode = 2'd0; stop2 = 1'b0;
        send_capture(8'hA5, D3, bits, blen);
        chk_int("8n1_len", blen, 40);
        chk_int("8n1_bits", int'(bits), 16'h034A);
        repeat (3) tick();

        // 7E2, 0x53
        dbits = 2'd2; pmode = 2'd1; stop2 = 1'b1;
        send_capture(8'h53, D3, bits, blen);
        chk_int("7e2_len", blen, 44);
        chk_int("7e2_bits", int'(bits), 16'h06A6);
        repeat (3) tick();

        // 5O1, 0xFF
        dbits = 2'd0; pmode = 2'd2; stop2 = 1'b0;
        send_capture(8'hFF, D3, bits, blen);
        chk_int("5o1_len", blen, 32);
        chk_int("5o1_bits", int'(bits), 16'h00BE);
        repeat (3) tick();

        // Overflow with six consecutive writes into a 4-deep FIFO
        dbits = 2'd3; pmode = 2'd0; stop2 = 1'b0;
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        chk("ovf_full_after3", bus.buffer_full, 1'b0);
        write_byte(8'h44);
        chk("ovf_full_after4", bus.buffer_full, 1'b1);
        write_byte(8'h55);
        chk("ovf_full_after5", bus.buffer_full, 1'b1);
        chk("ovf_no_flag_yet", bus.overflow, 1'b0);
        write_byte(8'h66);
        chk("ovf_flag", bus.overflow, 1'b1);
        wait_idle();
        chk_int("ovf_five_frames_len", last_run, 200);
        chk("ovf_sticky", bus.overflow, 1'b1);
        repeat (3) tick();

        // Baud change during the first of two queued frames
        write_byte(8'h3C);
        write_byte(8'hC3);
        repeat (10) @(negedge clock);
        baud = 2'd0;
        wait_idle();
        chk_int("cfg_change_len", last_run, 40 + 10 * D0);
        baud = 2'd3;
        repeat (3) tick();

        // Reset during data bit 3 with two bytes still queued
        write_byte(8'h00);
        write_byte(8'h81);
        write_byte(8'h7E);
        repeat (16) @(negedge clock);
        chk("mid_busy", busy, 1'b1);
        chk("mid_line_low", data_out, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_data_out", data_out, 1'b1);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_empty", bus.buffer_empty, 1'b1);
        chk("rst_mid_overflow", bus.overflow, 1'b0);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        chk("post_rst_line", data_out, 1'b1);
        chk("post_rst_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
